cm0_core_mul_iter: RTL and testbench
====================================

CM0_CORE_MUL_ITER -- requirements
Module: cm0_core_mul_iter

Interface
REQ-001 SHALL have parameter DW, default 32, operand width; legal values are even, 8..64.
REQ-002 SHALL have parameter RBITS, default 1, multiplier bits retired per cycle; legal values are 1, 2 or 4, and DW mod RBITS = 0.
REQ-003 SHALL have port hclk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port mul_start_i  input  1  request to start a multiply.
REQ-006 SHALL have port mul_abort_i  input  1  abandon the operation in flight (exception entry).
REQ-007 SHALL have port mul_signed_i  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-008 SHALL have port mul_opa_i  input  DW  multiplier operand; sampled with start.
REQ-009 SHALL have port mul_opb_i  input  DW  multiplicand operand; sampled with start.
REQ-010 SHALL have port mul_busy_o  output  1  high while in RUN.
REQ-011 SHALL have port mul_done_o  output  1  single-cycle result-valid strobe.
REQ-012 SHALL have port mul_res_lo_o  output  DW  low half of the product.
REQ-013 SHALL have port mul_res_hi_o  output  DW  high half of the product; present only when CM0_MUL_HI_RESULT_EN is defined.

Function
REQ-014 SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-015 SHALL, in IDLE or DONE, accept mul_start_i=1 when mul_abort_i=0, register the operands and mode, clear the accumulator, load N = DW/RBITS into the iteration counter and enter RUN.
REQ-016 SHALL, in RUN, retire RBITS multiplier bits per cycle (shift-add of RBITS partial products into a 2*DW accumulator), decrement the counter, and enter DONE after exactly N RUN cycles.
REQ-017 SHALL place the start cycle at cycle 0, RUN at cycles 1..N and DONE at cycle N+1; latency from start to done is N+1 cycles.
REQ-018 SHALL leave DONE after one cycle, to RUN if a start is accepted that cycle and to IDLE otherwise, so back-to-back operations have no idle gap.
REQ-019 SHALL ignore mul_start_i while in RUN.
REQ-020 SHALL make mul_busy_o equal to (state==RUN) and mul_done_o equal to (state==DONE).
REQ-021 SHALL produce the exact 2*DW-bit product: the two's-complement product when mul_signed_i=1 and the unsigned product otherwise; mul_res_lo_o is identical for both modes.
REQ-022 SHALL force mul_res_lo_o and mul_res_hi_o to all-zero whenever mul_done_o=0, so they can be OR-combined into the write-back mux.
REQ-023 SHALL, on mul_abort_i=1 in RUN, return to IDLE on the next edge with no done pulse and leave the accumulator value don't-care.
REQ-024 SHALL give mul_abort_i priority over a simultaneous mul_start_i in IDLE or DONE, ignoring the start.
REQ-025 SHALL let mul_abort_i have no effect on the DONE-cycle outputs.
REQ-026 SHALL load the operand and accumulator registers only on an accepted start or a RUN cycle, for power.

Reset
REQ-027 SHALL, with rst_n=0, enter IDLE immediately and clear the counter, accumulator and operand registers, regardless of hclk.
REQ-028 SHALL drive mul_busy_o=0, mul_done_o=0 and all-zero result outputs during and after reset.
REQ-029 SHALL, on reset during RUN, abandon the operation with no done pulse after reset release.

Configuration
REQ-030 SHALL, with CM0_MUL_HI_RESULT_EN defined, implement the full 2*DW accumulator, the signed high-half correction, and the mul_res_hi_o port.
REQ-031 SHALL, without CM0_MUL_HI_RESULT_EN, omit mul_res_hi_o, use a DW-bit accumulator, and leave mul_signed_i functionally unused; mul_res_lo_o and all timing are unchanged.

Verification
REQ-032 SHALL check: DW=32, RBITS=1, start with 7*6 -> busy high cycles 1..32, done in cycle 33 only, res_lo=0x0000002A, outputs zero in all other cycles.
REQ-033 SHALL check: hi enabled, 0xFFFFFFFF*0x00000002 -> signed gives lo=0xFFFFFFFE, hi=0xFFFFFFFF; unsigned gives lo=0xFFFFFFFE, hi=0x00000001.
REQ-034 SHALL check: RBITS=4, unsigned 0xFFFFFFFF*0xFFFFFFFF -> done in cycle 9, lo=0x00000001, hi=0xFFFFFFFE.
REQ-035 SHALL check: abort in cycle 10 of RUN -> IDLE in cycle 11, no done pulse, results zero; abort with start in IDLE -> start ignored.
REQ-036 SHALL check: start asserted in the DONE cycle -> the next done arrives N+1 cycles later; start held during RUN -> ignored.
REQ-037 SHALL check: rst_n low mid-RUN, asynchronous to hclk -> outputs zero immediately and no done pulse after release.

Source files
------------

// File: rtl/cm0_core_mul_iter.sv
// Iterative shift-add multiplier retiring RBITS multiplier bits per cycle; result in cycle DW/RBITS+1 after start.
// Latency: N+1 cycles (N = DW/RBITS); start is ignored while busy, abort drops the operation without a done pulse.
// Optional high half and signed mode enabled by defining CM0_MUL_HI_RESULT_EN.
module cm0_core_mul_iter #(
    parameter int DW    = 32,
    parameter int RBITS = 1
) (
    input  logic          hclk,
    input  logic          rst_n,
    input  logic          mul_start_i,
    input  logic          mul_abort_i,
    input  logic          mul_signed_i,
    input  logic [DW-1:0] mul_opa_i,
    input  logic [DW-1:0] mul_opb_i,
    output logic          mul_busy_o,
    output logic          mul_done_o,
    output logic [DW-1:0] mul_res_lo_o
`ifdef CM0_MUL_HI_RESULT_EN
    ,
    output logic [DW-1:0] mul_res_hi_o
`endif
);

    localparam int N  = DW / RBITS;
    localparam int CW = $clog2(N + 1);
`ifdef CM0_MUL_HI_RESULT_EN
    localparam int AW = 2 * DW;
`else
    localparam int AW = DW;
`endif

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    logic          busy_q;
    logic          done_q;
    logic [CW-1:0] cnt;
    logic [DW-1:0] opa_q;
    logic [AW-1:0] opb_q;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_nxt;
    logic          accept;
    logic          last;

`ifdef CM0_MUL_HI_RESULT_EN
    logic          sgn_q;
`else
    logic          sgn_unused;
    assign sgn_unused = mul_signed_i;
`endif

    assign accept = (state != RUN) && mul_start_i && !mul_abort_i;
    assign last   = (cnt == CW'(1));

    // opb_q is pre-shifted to the weight of the current multiplier digit.
    always_comb begin
        acc_nxt = acc;
        for (int i = 0; i < RBITS; i++) begin
            if (opa_q[i]) begin
                acc_nxt = acc_nxt + (opb_q << i);
            end
        end
`ifdef CM0_MUL_HI_RESULT_EN
        // Multiplier MSB carries weight -2^(DW-1) when signed: undo the +b and apply -b.
        if (last && sgn_q && opa_q[RBITS-1]) begin
            acc_nxt = acc_nxt - (opb_q << RBITS);
        end
`endif
    end

    always_ff @(posedge hclk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt    <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
            acc    <= '0;
`ifdef CM0_MUL_HI_RESULT_EN
            sgn_q  <= 1'b0;
`endif
        end else begin
            case (state)
                RUN: begin
                    if (mul_abort_i) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b0;
                    end else begin
                        acc   <= acc_nxt;
                        opa_q <= opa_q >> RBITS;
                        opb_q <= opb_q << RBITS;
                        cnt   <= cnt - CW'(1);
                        if (last) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (accept) begin
                        state  <= RUN;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                        cnt    <= CW'(N);
                        opa_q  <= mul_opa_i;
                        acc    <= '0;
`ifdef CM0_MUL_HI_RESULT_EN
                        sgn_q  <= mul_signed_i;
                        opb_q  <= {{DW{mul_signed_i & mul_opb_i[DW-1]}}, mul_opb_i};
`else
                        opb_q  <= mul_opb_i;
`endif
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign mul_busy_o   = busy_q;
    assign mul_done_o   = done_q;
    assign mul_res_lo_o = done_q ? acc[DW-1:0] : '0;
`ifdef CM0_MUL_HI_RESULT_EN
    assign mul_res_hi_o = done_q ? acc[AW-1:DW] : '0;
`endif

endmodule

// File: tb/tb_cm0_core_mul_iter.sv
// Bench for cm0_core_mul_iter: three DW=32 instances (RBITS 1, 2, 4) against an arithmetic product model.
module tb_cm0_core_mul_iter;

    logic        hclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start [3];
    logic        abort [3];
    logic        sgnv  [3];
    logic [31:0] opa   [3];
    logic [31:0] opb   [3];
    logic        busy  [3];
    logic        done  [3];
    logic [31:0] lo    [3];
    logic [31:0] hi    [3];

    int vectors = 0;
    int miscompares = 0;

    always #5 hclk = ~hclk;

`ifdef CM0_MUL_HI_RESULT_EN
    cm0_core_mul_iter #(.DW(32), .RBITS(1)) u_r1 (
        .hclk(hclk), .rst_n(rst_n), .mul_start_i(start[0]), .mul_abort_i(abort[0]),
        .mul_signed_i(sgnv[0]), .mul_opa_i(opa[0]), .mul_opb_i(opb[0]), .mul_busy_o(busy[0]),
        .mul_done_o(done[0]), .mul_res_lo_o(lo[0]), .mul_res_hi_o(hi[0]));
    cm0_core_mul_iter #(.DW(32), .RBITS(2)) u_r2 (
        .hclk(hclk), .rst_n(rst_n), .mul_start_i(start[1]), .mul_abort_i(abort[1]),
        .mul_signed_i(sgnv[1]), .mul_opa_i(opa[1]), .mul_opb_i(opb[1]), .mul_busy_o(busy[1]),
        .mul_done_o(done[1]), .mul_res_lo_o(lo[1]), .mul_res_hi_o(hi[1]));
    cm0_core_mul_iter #(.DW(32), .RBITS(4)) u_r4 (
        .hclk(hclk), .rst_n(rst_n), .mul_start_i(start[2]), .mul_abort_i(abort[2]),
        .mul_signed_i(sgnv[2]), .mul_opa_i(opa[2]), .mul_opb_i(opb[2]), .mul_busy_o(busy[2]),
        .mul_done_o(done[2]), .mul_res_lo_o(lo[2]), .mul_res_hi_o(hi[2]));
`else
    cm0_core_mul_iter #(.DW(32), .RBITS(1)) u_r1 (
        .hclk(hclk), .rst_n(rst_n), .mul_start_i(start[0]), .mul_abort_i(abort[0]),
        .mul_signed_i(sgnv[0]), .mul_opa_i(opa[0]), .mul_opb_i(opb[0]), .mul_busy_o(busy[0]),
        .mul_done_o(done[0]), .mul_res_lo_o(lo[0]));
    cm0_core_mul_iter #(.DW(32), .RBITS(2)) u_r2 (
        .hclk(hclk), .rst_n(rst_n), .mul_start_i(start[1]), .mul_abort_i(abort[1]),
        .mul_signed_i(sgnv[1]), .mul_opa_i(opa[1]), .mul_opb_i(opb[1]), .mul_busy_o(busy[1]),
        .mul_done_o(done[1]), .mul_res_lo_o(lo[1]));
    cm0_core_mul_iter #(.DW(32), .RBITS(4)) u_r4 (
        .hclk(hclk), .rst_n(rst_n), .mul_start_i(start[2]), .mul_abort_i(abort[2]),
        .mul_signed_i(sgnv[2]), .mul_opa_i(opa[2]), .mul_opb_i(opb[2]), .mul_busy_o(busy[2]),
        .mul_done_o(done[2]), .mul_res_lo_o(lo[2]));
    assign hi[0] = 32'h0;
    assign hi[1] = 32'h0;
    assign hi[2] = 32'h0;
`endif

    function automatic int nn(int i);
        return 32 >> i;
    endfunction

    function automatic logic [63:0] model(logic [31:0] a, logic [31:0] b, logic s);
        logic [63:0] ea, eb;
        ea = s ? {{32{a[31]}}, a} : {32'h0, a};
        eb = s ? {{32{b[31]}}, b} : {32'h0, b};
        return ea * eb;
    endfunction

    function automatic logic [65:0] expv(logic b, logic d, logic [63:0] p);
        logic [31:0] l, h;
        l = d ? p[31:0] : 32'h0;
`ifdef CM0_MUL_HI_RESULT_EN
        h = d ? p[63:32] : 32'h0;
`else
        h = 32'h0;
`endif
        return {b, d, l, h};
    endfunction

    function automatic logic [65:0] obs(int i);
        return {busy[i], done[i], lo[i], hi[i]};
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] c [5];
        c[0] = 32'h0; c[1] = 32'h1; c[2] = 32'hFFFF_FFFF; c[3] = 32'h8000_0000; c[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    task automatic drive(int i, logic s, logic ab, logic sg, logic [31:0] a, logic [31:0] b);
        start[i] = s;
        abort[i] = ab;
        sgnv[i]  = sg;
        opa[i]   = a;
        opb[i]   = b;
    endtask

    task automatic test_reset();
        logic [65:0] got;
        #1;
        for (int i = 0; i < 3; i++) begin
            got = obs(i);
            vectors++;
            if (got !== 66'h0) begin
                miscompares++;
                $display("FAIL reset_during inst=%0d got=%h want=0", i, got);
            end
        end
        repeat (2) @(negedge hclk);
        rst_n = 1'b1;
        repeat (2) @(negedge hclk);
        for (int i = 0; i < 3; i++) begin
            got = obs(i);
            vectors++;
            if (got !== 66'h0) begin
                miscompares++;
                $display("FAIL reset_after inst=%0d got=%h want=0", i, got);
            end
        end
    endtask

    task automatic test_directed();
        int          ti [6];
        logic [31:0] ta [6];
        logic [31:0] tb [6];
        logic        ts [6];
        logic [63:0] p;
        logic [65:0] got, want;
        int          n;
        ti[0] = 0; ta[0] = 32'h7;         tb[0] = 32'h6;         ts[0] = 1'b0;
        ti[1] = 0; ta[1] = 32'hFFFF_FFFF; tb[1] = 32'h2;         ts[1] = 1'b1;
        ti[2] = 0; ta[2] = 32'hFFFF_FFFF; tb[2] = 32'h2;         ts[2] = 1'b0;
        ti[3] = 2; ta[3] = 32'hFFFF_FFFF; tb[3] = 32'hFFFF_FFFF; ts[3] = 1'b0;
        ti[4] = 1; ta[4] = 32'h8000_0000; tb[4] = 32'h8000_0000; ts[4] = 1'b1;
        ti[5] = 2; ta[5] = 32'h8000_0000; tb[5] = 32'hFFFF_FFFF; ts[5] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            n = nn(ti[k]);
            p = model(ta[k], tb[k], ts[k]);
            @(negedge hclk);
            drive(ti[k], 1'b1, 1'b0, ts[k], ta[k], tb[k]);
            for (int c = 1; c <= n + 2; c++) begin
                @(negedge hclk);
                if (c == 1) drive(ti[k], 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
                want = expv(c <= n, c == n + 1, p);
                got  = obs(ti[k]);
                vectors++;
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL directed case=%0d cycle=%0d got=%h want=%h", k, c, got, want);
                end
            end
        end
    endtask

    task automatic test_random();
        int          i, n;
        logic [31:0] a, b;
        logic        s;
        logic [63:0] p;
        logic [65:0] got, want;
        for (int t = 0; t < 24; t++) begin
            i = $urandom_range(0, 2);
            n = nn(i);
            a = pick();
            b = pick();
            s = 1'($urandom_range(0, 1));
            p = model(a, b, s);
            @(negedge hclk);
            drive(i, 1'b1, 1'b0, s, a, b);
            for (int c = 1; c <= n + 1; c++) begin
                @(negedge hclk);
                if (c == 1) drive(i, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
                if (c == 1 || c >= n) begin
                    want = expv(c <= n, c == n + 1, p);
                    got  = obs(i);
                    vectors++;
                    if (got !== want) begin
                        miscompares++;
                        $display("FAIL random t=%0d inst=%0d a=%h b=%h s=%0d cycle=%0d got=%h want=%h",
                                 t, i, a, b, s, c, got, want);
                    end
                end
            end
        end
    endtask

    task automatic test_abort();
        logic [65:0] got, want;
        logic [63:0] p;
        // Abort in cycle 10 of RUN.
        @(negedge hclk);
        drive(0, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
        for (int c = 1; c <= 14; c++) begin
            @(negedge hclk);
            if (c == 1)  drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            if (c == 10) abort[0] = 1'b1;
            if (c == 11) abort[0] = 1'b0;
            want = expv(c <= 10, 1'b0, 64'h0);
            got  = obs(0);
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL abort_run cycle=%0d got=%h want=%h", c, got, want);
            end
        end
        // Abort with start in IDLE: start is dropped.
        @(negedge hclk);
        drive(0, 1'b1, 1'b1, 1'b0, 32'h5, 32'h5);
        for (int c = 1; c <= 34; c++) begin
            @(negedge hclk);
            if (c == 1) drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            got = obs(0);
            vectors++;
            if (got !== 66'h0) begin
                miscompares++;
                $display("FAIL abort_idle cycle=%0d got=%h want=0", c, got);
            end
        end
        // Abort plus start in DONE: done outputs intact, then IDLE.
        p = model(32'hDEAD_BEEF, 32'h0000_0101, 1'b0);
        @(negedge hclk);
        drive(2, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0101);
        for (int c = 1; c <= 11; c++) begin
            @(negedge hclk);
            if (c == 1)  drive(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            if (c == 9)  drive(2, 1'b1, 1'b1, 1'b0, 32'h3, 32'h3);
            if (c == 10) drive(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            want = expv(c <= 8, c == 9, p);
            got  = obs(2);
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL abort_done cycle=%0d got=%h want=%h", c, got, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          n;
        logic [31:0] a1, b1, a2, b2;
        logic        s1, s2;
        logic [63:0] p1, p2;
        logic [65:0] got, want;
        n  = nn(1);
        a1 = $urandom; b1 = $urandom; s1 = 1'($urandom_range(0, 1));
        a2 = $urandom; b2 = $urandom; s2 = 1'($urandom_range(0, 1));
        p1 = model(a1, b1, s1);
        p2 = model(a2, b2, s2);
        @(negedge hclk);
        drive(1, 1'b1, 1'b0, s1, a1, b1);
        for (int c = 1; c <= 2 * n + 3; c++) begin
            @(negedge hclk);
            if (c == 1) drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            if (c == n + 1) drive(1, 1'b1, 1'b0, s2, a2, b2);
            if (c >= n + 2 && c <= 2 * n + 1) drive(1, 1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
            if (c == 2 * n + 2) drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            if (c <= n + 1) want = expv(c <= n, c == n + 1, p1);
            else            want = expv(c <= 2 * n + 1, c == 2 * n + 2, p2);
            got = obs(1);
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL back_to_back cycle=%0d got=%h want=%h", c, got, want);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [65:0] got, want;
        @(negedge hclk);
        drive(0, 1'b1, 1'b0, 1'b1, 32'hCAFE_F00D, 32'h0BAD_BEEF);
        for (int c = 1; c <= 10; c++) begin
            @(negedge hclk);
            if (c == 1) drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        want = expv(1'b1, 1'b0, 64'h0);
        got  = obs(0);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL async_pre got=%h want=%h", got, want);
        end
        @(posedge hclk);
        #3;
        rst_n = 1'b0;
        #1;
        got = obs(0);
        vectors++;
        if (got !== 66'h0) begin
            miscompares++;
            $display("FAIL async_immediate got=%h want=0", got);
        end
        repeat (2) @(negedge hclk);
        rst_n = 1'b1;
        for (int c = 1; c <= 36; c++) begin
            @(negedge hclk);
            got = obs(0);
            vectors++;
            if (got !== 66'h0) begin
                miscompares++;
                $display("FAIL async_after cycle=%0d got=%h want=0", c, got);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        test_reset();
        test_directed();
        test_random();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
